writeback_stage: RTL

- Final pipeline stage of the RV32I core. Consumes results from the exec stage and the dmem (load) stage.
- Commits results to the 32x32 general register file and owns the architectural PC; both are exported to the exec/dmem side as curr_general_reg / curr_pc_reg equivalents.
- Issues a one-cycle flush on any control-flow redirect (taken branch, JAL, JALR).

---
 rtl/writeback_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Writeback stage of the RV32I core: commits exec and load results to the
// register file, owns the architectural PC and raises a one-cycle flush on redirect.
module writeback_stage #(
  parameter int                 BIN_DIG  = 32,
  parameter int                 REG_NUM  = 32,
  parameter logic [BIN_DIG-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [4:0]         ex_rd,
  input  logic               ex_rd_we,
  input  logic [BIN_DIG-1:0] ex_rd_value,
  input  logic               ex_pc_we,
  input  logic [BIN_DIG-1:0] ex_next_pc,
  input  logic               dm_valid,
  output logic               dm_ready,
  input  logic [4:0]         dm_rd,
  input  logic [BIN_DIG-1:0] dm_rd_value,
  input  logic [4:0]         rd_addr_a,
  output logic [BIN_DIG-1:0] rd_data_a,
  input  logic [4:0]         rd_addr_b,
  output logic [BIN_DIG-1:0] rd_data_b,
  output logic [BIN_DIG-1:0] curr_pc_reg,
  output logic               flush,
  output logic               misalign_err,
  output logic [31:0]        retire_count
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t             state_r;
  logic [BIN_DIG-1:0] regs_r [REG_NUM];
  logic [BIN_DIG-1:0] pc_r;
  logic               flush_r;
  logic               misalign_r;
  logic [31:0]        retire_r;

  logic               dm_xfer_s;
  logic               ex_xfer_s;
  logic               wr_en_s;
  logic [4:0]         wr_addr_s;
  logic [BIN_DIG-1:0] wr_data_s;
  logic [BIN_DIG-1:0] pc_target_s;

  // Handshake arbitration: a pending load always wins over an exec result.
  always_comb begin
    dm_ready  = 1'b0;
    ex_ready  = 1'b0;
    dm_xfer_s = 1'b0;
    ex_xfer_s = 1'b0;
    if (state_r == RUN) begin
      dm_ready  = 1'b1;
      ex_ready  = ~dm_valid;
      dm_xfer_s = dm_valid & ~rst;
      ex_xfer_s = ex_valid & ~dm_valid & ~rst;
    end else begin
      dm_ready  = 1'b0;
      ex_ready  = 1'b0;
    end
  end

  // Select the single register write of this cycle; x0 writes are dropped here.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_addr_s   = 5'd0;
    wr_data_s   = {BIN_DIG{1'b0}};
    pc_target_s = ex_next_pc & ~BIN_DIG'(1);
    if (dm_xfer_s) begin
      wr_en_s   = (dm_rd != 5'd0);
      wr_addr_s = dm_rd;
      wr_data_s = dm_rd_value;
    end else if (ex_xfer_s) begin
      wr_en_s   = ex_rd_we & (ex_rd != 5'd0);
      wr_addr_s = ex_rd;
      wr_data_s = ex_rd_value;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Read ports with write-through bypass so a consumer sees this cycle's result.
  always_comb begin
    rd_data_a = {BIN_DIG{1'b0}};
    rd_data_b = {BIN_DIG{1'b0}};
    if (rd_addr_a == 5'd0) begin
      rd_data_a = {BIN_DIG{1'b0}};
    end else if (wr_en_s && (rd_addr_a == wr_addr_s)) begin
      rd_data_a = wr_data_s;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
    if (rd_addr_b == 5'd0) begin
      rd_data_b = {BIN_DIG{1'b0}};
    end else if (wr_en_s && (rd_addr_b == wr_addr_s)) begin
      rd_data_b = wr_data_s;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_r[i] <= {BIN_DIG{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Commit FSM: PC, retire counter, sticky misalignment and the flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      pc_r       <= RESET_PC;
      flush_r    <= 1'b0;
      misalign_r <= 1'b0;
      retire_r   <= 32'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (dm_xfer_s || ex_xfer_s) begin
            retire_r <= retire_r + 32'd1;
          end
          if (ex_xfer_s && ex_pc_we) begin
            state_r <= REDIRECT;
            flush_r <= 1'b1;
            pc_r    <= pc_target_s;
            if (ex_next_pc[1]) begin
              misalign_r <= 1'b1;
            end
          end else begin
            flush_r <= 1'b0;
            if (dm_xfer_s || ex_xfer_s) begin
              pc_r <= pc_r + BIN_DIG'(4);
            end
          end
        end
        REDIRECT: begin
          state_r <= RUN;
          flush_r <= 1'b0;
        end
        default: begin
          state_r <= RUN;
          flush_r <= 1'b0;
        end
      endcase
    end
  end

  assign curr_pc_reg  = pc_r;
  assign flush        = flush_r;
  assign misalign_err = misalign_r;
  assign retire_count = retire_r;

endmodule
